// File: rtl/boolfunc_tt_extractor.sv
// Sweeps all 16 {A,B,C,D} vectors into a function under test and recovers its truth table,
// minterm count and 8x1-mux residue codes. Define TT_MISMATCH_CHECK_EN to add a compare against expected_tt.
module boolfunc_tt_extractor #(
  parameter int SETTLE_CYCLES = 2,
  parameter int SETTLE_W      = 4
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                start,
  input  logic                func_in,
  output logic [3:0]          probe_out,
  output logic                busy,
  output logic                done,
  output logic [15:0]         truth_table,
  output logic [4:0]          minterm_count,
  output logic [15:0]         mux_code
`ifdef TT_MISMATCH_CHECK_EN
  ,
  input  logic [15:0]         expected_tt,
  output logic                match,
  output logic [15:0]         mismatch_mask
`endif
);

  typedef enum logic [1:0] {IDLE, SETTLE, SAMPLE, DONE} state_t;

  localparam logic [SETTLE_W-1:0] SETTLE_LAST = SETTLE_W'(SETTLE_CYCLES - 1);

  state_t              state;
  logic [3:0]          index;
  logic [SETTLE_W-1:0] settle_cnt;
  logic [15:0]         shadow;
  logic [4:0]          next_count;
  logic [15:0]         next_code;

  // Residue code per select s is {F(A=1,s), F(A=0,s)}: 00=0, 11=1, 10=A, 01=~A.
  always_comb begin
    next_count = 5'd0;
    next_code  = 16'd0;
    for (int i = 0; i < 16; i++) begin
      next_count = next_count + {4'd0, shadow[i]};
    end
    for (int s = 0; s < 8; s++) begin
      next_code[2*s +: 2] = {shadow[8+s], shadow[s]};
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state         <= IDLE;
      index         <= 4'd0;
      settle_cnt    <= '0;
      shadow        <= 16'd0;
      probe_out     <= 4'd0;
      busy          <= 1'b0;
      done          <= 1'b0;
      truth_table   <= 16'd0;
      minterm_count <= 5'd0;
      mux_code      <= 16'd0;
`ifdef TT_MISMATCH_CHECK_EN
      match         <= 1'b0;
      mismatch_mask <= 16'd0;
`endif
    end else begin
      case (state)
        IDLE: begin
          done <= 1'b0;
          if (start) begin
            state      <= SETTLE;
            index      <= 4'd0;
            probe_out  <= 4'd0;
            settle_cnt <= '0;
            shadow     <= 16'd0;
            busy       <= 1'b1;
          end
        end
        SETTLE: begin
          if (settle_cnt == SETTLE_LAST) begin
            state <= SAMPLE;
          end else begin
            settle_cnt <= settle_cnt + 1'b1;
          end
        end
        SAMPLE: begin
          shadow[index] <= func_in;
          if (index == 4'd15) begin
            state <= DONE;
          end else begin
            index      <= index + 4'd1;
            probe_out  <= index + 4'd1;
            settle_cnt <= '0;
            state      <= SETTLE;
          end
        end
        DONE: begin
          // Published results change only here, so a partial sweep is never visible.
          truth_table   <= shadow;
          minterm_count <= next_count;
          mux_code      <= next_code;
`ifdef TT_MISMATCH_CHECK_EN
          mismatch_mask <= shadow ^ expected_tt;
          match         <= (shadow == expected_tt);
`endif
          done  <= 1'b1;
          busy  <= 1'b0;
          state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_boolfunc_tt_extractor.sv
// Directed self-checking bench for boolfunc_tt_extractor; honours TT_MISMATCH_CHECK_EN when defined.
module tb_boolfunc_tt_extractor;

  logic        clk;
  logic        rst_n;
  logic        start;
  logic        func_in;
  logic [3:0]  probe_out;
  logic        busy;
  logic        done;
  logic [15:0] truth_table;
  logic [4:0]  minterm_count;
  logic [15:0] mux_code;
`ifdef TT_MISMATCH_CHECK_EN
  logic [15:0] expected_tt;
  logic        match;
  logic [15:0] mismatch_mask;
`endif

  int n_checks;
  int n_fail;
  int func_sel;
  int done_cyc;
  int done_cnt;
  int busy_gap;

  boolfunc_tt_extractor #(.SETTLE_CYCLES(2), .SETTLE_W(4)) dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .start         (start),
    .func_in       (func_in),
    .probe_out     (probe_out),
    .busy          (busy),
    .done          (done),
    .truth_table   (truth_table),
    .minterm_count (minterm_count),
    .mux_code      (mux_code)
`ifdef TT_MISMATCH_CHECK_EN
    ,
    .expected_tt   (expected_tt),
    .match         (match),
    .mismatch_mask (mismatch_mask)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Function under test selected by func_sel: 0 const0, 1 const1, 2 A, 3 ~A, 4 sum of minterms (3,5,7,8,10,11,13,15).
  always_comb begin
    func_in = 1'b0;
    case (func_sel)
      1: func_in = 1'b1;
      2: func_in = probe_out[3];
      3: func_in = ~probe_out[3];
      4: func_in = (probe_out inside {4'd3, 4'd5, 4'd7, 4'd8, 4'd10, 4'd11, 4'd13, 4'd15});
      default: func_in = 1'b0;
    endcase
  end

  task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    n_checks++;
    assert (observed === expected)
    else begin
      n_fail++;
      $error("[TB] FAIL %s observed=%0h expected=%0h", tag, observed, expected);
    end
  endtask

  // Pulses start, then watches a fixed 60-cycle window; cycle numbers count edges after acceptance edge E0.
  task automatic applyStimulus(input int restart_cyc, output int first_done, output int n_done, output int gaps);
    first_done = 0;
    n_done     = 0;
    gaps       = 0;
    @(negedge clk);
    start = 1'b1;
    @(posedge clk);
    #1 start = 1'b0;
    for (int c = 1; c <= 60; c++) begin
      @(posedge clk);
      #1;
      if (done) begin
        n_done++;
        if (first_done == 0) first_done = c;
      end
      if (first_done == 0 && !done && !busy) gaps++;
      if (c == restart_cyc) start = 1'b1;
      if (c == restart_cyc + 1) start = 1'b0;
    end
  endtask

  task automatic checkSweep(input string tag, input logic [15:0] tt, input logic [4:0] cnt, input logic [15:0] code);
    checkOutput({tag, ".done_cycle"}, 32'(done_cyc), 32'd49);
    checkOutput({tag, ".done_pulses"}, 32'(done_cnt), 32'd1);
    checkOutput({tag, ".truth_table"}, {16'd0, truth_table}, {16'd0, tt});
    checkOutput({tag, ".minterm_count"}, {27'd0, minterm_count}, {27'd0, cnt});
    checkOutput({tag, ".mux_code"}, {16'd0, mux_code}, {16'd0, code});
    checkOutput({tag, ".busy_after"}, {31'd0, busy}, 32'd0);
  endtask

  initial begin
    n_checks = 0;
    n_fail   = 0;
    func_sel = 4;
    start    = 1'b0;
    rst_n    = 1'b0;
`ifdef TT_MISMATCH_CHECK_EN
    expected_tt = 16'hADA8;
`endif
    repeat (3) @(posedge clk);
    #1;
    checkOutput("reset.probe_out", {28'd0, probe_out}, 32'd0);
    checkOutput("reset.busy", {31'd0, busy}, 32'd0);
    checkOutput("reset.done", {31'd0, done}, 32'd0);
    checkOutput("reset.truth_table", {16'd0, truth_table}, 32'd0);
    checkOutput("reset.minterm_count", {27'd0, minterm_count}, 32'd0);
    checkOutput("reset.mux_code", {16'd0, mux_code}, 32'd0);
    @(negedge clk);
    rst_n = 1'b1;

    $display("[TB] sweep of sum-of-minterms function");
    func_sel = 4;
    applyStimulus(0, done_cyc, done_cnt, busy_gap);
    checkSweep("som", 16'hADA8, 5'd8, 16'hCCE2);
    checkOutput("som.busy_gap", 32'(busy_gap), 32'd0);
    checkOutput("som.probe_hold", {28'd0, probe_out}, 32'hF);
`ifdef TT_MISMATCH_CHECK_EN
    checkOutput("som.match", {31'd0, match}, 32'd1);
    checkOutput("som.mismatch_mask", {16'd0, mismatch_mask}, 32'd0);
    expected_tt = 16'hADA9;
    applyStimulus(0, done_cyc, done_cnt, busy_gap);
    checkOutput("som_bad.match", {31'd0, match}, 32'd0);
    checkOutput("som_bad.mismatch_mask", {16'd0, mismatch_mask}, 32'h0001);
    expected_tt = 16'hADA8;
`endif

    $display("[TB] constant functions");
    func_sel = 0;
    applyStimulus(0, done_cyc, done_cnt, busy_gap);
    checkSweep("const0", 16'h0000, 5'd0, 16'h0000);
    func_sel = 1;
    applyStimulus(0, done_cyc, done_cnt, busy_gap);
    checkSweep("const1", 16'hFFFF, 5'd16, 16'hFFFF);

    $display("[TB] residue-variable functions");
    func_sel = 2;
    applyStimulus(0, done_cyc, done_cnt, busy_gap);
    checkSweep("varA", 16'hFF00, 5'd8, 16'hAAAA);
    func_sel = 3;
    applyStimulus(0, done_cyc, done_cnt, busy_gap);
    checkSweep("notA", 16'h00FF, 5'd8, 16'h5555);

    $display("[TB] start re-pulsed at vector 5");
    func_sel = 4;
    applyStimulus(16, done_cyc, done_cnt, busy_gap);
    checkSweep("restart", 16'hADA8, 5'd8, 16'hCCE2);
    checkOutput("restart.busy_gap", 32'(busy_gap), 32'd0);

    $display("[TB] reset asserted at vector 9");
    @(negedge clk);
    start = 1'b1;
    @(posedge clk);
    #1 start = 1'b0;
    repeat (28) @(posedge clk);
    #2 rst_n = 1'b0;
    #1;
    checkOutput("midrst.truth_table", {16'd0, truth_table}, 32'd0);
    checkOutput("midrst.minterm_count", {27'd0, minterm_count}, 32'd0);
    checkOutput("midrst.mux_code", {16'd0, mux_code}, 32'd0);
    checkOutput("midrst.busy", {31'd0, busy}, 32'd0);
    checkOutput("midrst.probe_out", {28'd0, probe_out}, 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    done_cnt = 0;
    for (int c = 0; c < 60; c++) begin
      @(posedge clk);
      #1;
      if (done) done_cnt++;
    end
    checkOutput("postrst.done_pulses", 32'(done_cnt), 32'd0);
    checkOutput("postrst.truth_table", {16'd0, truth_table}, 32'd0);
    checkOutput("postrst.busy", {31'd0, busy}, 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", n_checks, n_fail);
    $finish;
  end

endmodule
